// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V control unit: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer with retire counter.
// Optional macro ILLEGAL_TRAP_EN: illegal opcodes trap (sticky flag) instead of executing as a NOP.
module multicycle_control_unit #(
    parameter int unsigned OPCODE_W = 7,
    parameter int unsigned ALU_OP_W = 2,
    parameter int unsigned RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                arst,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                ir_write,
    output logic                pc_write,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                alu_src,
    output logic                branch,
    output logic                jump,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_2_reg,
    output logic                reg_write,
    output logic [2:0]          state,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_TRAP      = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_R   = 3'd0,
        C_I   = 3'd1,
        C_BR  = 3'd2,
        C_JAL = 3'd3,
        C_LD  = 3'd4,
        C_ST  = 3'd5,
        C_ILL = 3'd6
    } cls_t;

    typedef struct packed {
        logic                ir_write;
        logic                pc_write;
        logic [ALU_OP_W-1:0] alu_op;
        logic                alu_src;
        logic                branch;
        logic                jump;
        logic                mem_read;
        logic                mem_write;
        logic                mem_2_reg;
        logic                reg_write;
    } ctrl_t;

    localparam logic [OPCODE_W-1:0] OP_R   = OPCODE_W'(7'b0110011);
    localparam logic [OPCODE_W-1:0] OP_I   = OPCODE_W'(7'b0010011);
    localparam logic [OPCODE_W-1:0] OP_BR  = OPCODE_W'(7'b1100011);
    localparam logic [OPCODE_W-1:0] OP_JAL = OPCODE_W'(7'b1101111);
    localparam logic [OPCODE_W-1:0] OP_LD  = OPCODE_W'(7'b0000011);
    localparam logic [OPCODE_W-1:0] OP_ST  = OPCODE_W'(7'b0100011);

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(2'd0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(2'd1);
    localparam logic [ALU_OP_W-1:0] ALU_RTYP = ALU_OP_W'(2'd2);

    state_t              state_q, state_d;
    cls_t                cls_q, cls_dec;
    ctrl_t               ctl;
    logic                retire;
    logic [RETIRE_W-1:0] retired_q;

    // Opcode to instruction class; only consumed while in DECODE.
    always_comb begin
        cls_dec = C_ILL;
        case (opcode)
            OP_R:    cls_dec = C_R;
            OP_I:    cls_dec = C_I;
            OP_BR:   cls_dec = C_BR;
            OP_JAL:  cls_dec = C_JAL;
            OP_LD:   cls_dec = C_LD;
            OP_ST:   cls_dec = C_ST;
            default: cls_dec = C_ILL;
        endcase
    end

    // State, latched class and retire counter.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= S_IDLE;
            cls_q     <= C_R;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                cls_q <= cls_dec;
            end
            if (retire) begin
                retired_q <= retired_q + RETIRE_W'(1);
            end
        end
    end

    // Next state and Moore controls; pc_write in MEMORY follows mem_ready for stores.
    always_comb begin
        state_d = state_q;
        ctl     = '0;
        retire  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ctl.ir_write = 1'b1;
                state_d      = S_DECODE;
            end
            S_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
                state_d = (cls_dec == C_ILL) ? S_TRAP : S_EXECUTE;
`else
                state_d = S_EXECUTE;
`endif
            end
            S_EXECUTE: begin
                case (cls_q)
                    C_R: begin
                        ctl.alu_op = ALU_RTYP;
                        state_d    = S_WRITEBACK;
                    end
                    C_I: begin
                        ctl.alu_op  = ALU_RTYP;
                        ctl.alu_src = 1'b1;
                        state_d     = S_WRITEBACK;
                    end
                    C_LD, C_ST: begin
                        ctl.alu_op  = ALU_ADD;
                        ctl.alu_src = 1'b1;
                        state_d     = S_MEMORY;
                    end
                    C_BR: begin
                        ctl.alu_op   = ALU_SUB;
                        ctl.branch   = 1'b1;
                        ctl.pc_write = 1'b1;
                        retire       = 1'b1;
                        state_d      = S_FETCH;
                    end
                    C_JAL: begin
                        ctl.alu_op   = ALU_ADD;
                        ctl.jump     = 1'b1;
                        ctl.pc_write = 1'b1;
                        retire       = 1'b1;
                        state_d      = S_FETCH;
                    end
                    default: begin
                        // Illegal opcode executes as a NOP: advance PC, nothing retires.
                        ctl.pc_write = 1'b1;
                        state_d      = S_FETCH;
                    end
                endcase
            end
            S_MEMORY: begin
                ctl.alu_op  = ALU_ADD;
                ctl.alu_src = 1'b1;
                if (cls_q == C_LD) begin
                    ctl.mem_read = 1'b1;
                end else begin
                    ctl.mem_write = 1'b1;
                end
                if (mem_ready) begin
                    if (cls_q == C_LD) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        ctl.pc_write = 1'b1;
                        retire       = 1'b1;
                        state_d      = S_FETCH;
                    end
                end
            end
            S_WRITEBACK: begin
                ctl.reg_write = 1'b1;
                ctl.pc_write  = 1'b1;
                ctl.mem_2_reg = (cls_q == C_LD);
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky until reset.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            illegal_q <= 1'b0;
        end else if (state_q == S_DECODE && cls_dec == C_ILL) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    assign ir_write  = ctl.ir_write;
    assign pc_write  = ctl.pc_write;
    assign alu_op    = ctl.alu_op;
    assign alu_src   = ctl.alu_src;
    assign branch    = ctl.branch;
    assign jump      = ctl.jump;
    assign mem_read  = ctl.mem_read;
    assign mem_write = ctl.mem_write;
    assign mem_2_reg = ctl.mem_2_reg;
    assign reg_write = ctl.reg_write;
    assign state     = state_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: instruction-level vector table, per-cycle timeline model, corner sequences.
module tb_multicycle_control_unit;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic       run = 1'b0;
    logic       mem_ready = 1'b0;
    logic [6:0] opcode = 7'd0;

    logic        ir_write, pc_write, alu_src, branch, jump, mem_read, mem_write, mem_2_reg, reg_write, illegal;
    logic [1:0]  alu_op;
    logic [2:0]  state;
    logic [31:0] retired;

    logic        ir_write_b, pc_write_b, alu_src_b, branch_b, jump_b, mem_read_b, mem_write_b, mem_2_reg_b, reg_write_b, illegal_b;
    logic [1:0]  alu_op_b;
    logic [2:0]  state_b;
    logic [3:0]  retired_b;

    multicycle_control_unit dut (
        .clk(clk), .arst(arst), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .ir_write(ir_write), .pc_write(pc_write), .alu_op(alu_op), .alu_src(alu_src),
        .branch(branch), .jump(jump), .mem_read(mem_read), .mem_write(mem_write),
        .mem_2_reg(mem_2_reg), .reg_write(reg_write), .state(state), .illegal(illegal),
        .retired(retired)
    );

    multicycle_control_unit #(.RETIRE_W(4)) dut4 (
        .clk(clk), .arst(arst), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .ir_write(ir_write_b), .pc_write(pc_write_b), .alu_op(alu_op_b), .alu_src(alu_src_b),
        .branch(branch_b), .jump(jump_b), .mem_read(mem_read_b), .mem_write(mem_write_b),
        .mem_2_reg(mem_2_reg_b), .reg_write(reg_write_b), .state(state_b), .illegal(illegal_b),
        .retired(retired_b)
    );

    wire [10:0] ctl_a = {ir_write, pc_write, alu_op, alu_src, branch, jump, mem_read, mem_write, mem_2_reg, reg_write};
    wire [10:0] ctl_b = {ir_write_b, pc_write_b, alu_op_b, alu_src_b, branch_b, jump_b, mem_read_b, mem_write_b, mem_2_reg_b, reg_write_b};

    always #5 clk = ~clk;

    typedef struct packed {
        logic        run;
        logic [6:0]  opc;
        logic        rdy;
        logic [2:0]  st;
        logic [10:0] ctl;
        logic        ret;
    } cycle_t;

    typedef struct {
        logic [6:0] opc;
        int         w;
        int         len;
        int         ret;
        int         mem;
        logic [3:0] seen;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    int unsigned cnt = 0;
    cycle_t      sched[$];
    vec_t        tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [10:0] cv(input int ir, input int pc, input int aop, input int src, input int br,
                                       input int jp, input int mr, input int mw, input int m2r, input int rw);
        return {1'(ir), 1'(pc), 2'(aop), 1'(src), 1'(br), 1'(jp), 1'(mr), 1'(mw), 1'(m2r), 1'(rw)};
    endfunction

    task automatic push(input logic r, input logic [6:0] o, input logic y, input int st, input logic [10:0] c, input int ret);
        cycle_t e;
        e.run = r; e.opc = o; e.rdy = y; e.st = 3'(st); e.ctl = c; e.ret = 1'(ret);
        sched.push_back(e);
    endtask

    // Expected cycle-by-cycle timeline of one instruction; junk is driven on opcode outside DECODE.
    task automatic push_insn(input logic [6:0] op, input int w, input logic [6:0] junk);
        push(rb(), junk, rb(), 1, cv(1,0,0,0,0,0,0,0,0,0), 0);
        push(rb(), op,   rb(), 2, '0, 0);
        case (op)
            OP_R: begin
                push(rb(), junk, rb(), 3, cv(0,0,2,0,0,0,0,0,0,0), 0);
                push(rb(), junk, rb(), 5, cv(0,1,0,0,0,0,0,0,0,1), 1);
            end
            OP_I: begin
                push(rb(), junk, rb(), 3, cv(0,0,2,1,0,0,0,0,0,0), 0);
                push(rb(), junk, rb(), 5, cv(0,1,0,0,0,0,0,0,0,1), 1);
            end
            OP_BR:  push(rb(), junk, rb(), 3, cv(0,1,1,0,1,0,0,0,0,0), 1);
            OP_JAL: push(rb(), junk, rb(), 3, cv(0,1,0,0,0,1,0,0,0,0), 1);
            OP_LD: begin
                push(rb(), junk, rb(), 3, cv(0,0,0,1,0,0,0,0,0,0), 0);
                for (int i = 0; i < w; i++)
                    push(rb(), junk, (i == w - 1), 4, cv(0,0,0,1,0,0,1,0,0,0), 0);
                push(rb(), junk, rb(), 5, cv(0,1,0,0,0,0,0,0,1,1), 1);
            end
            OP_ST: begin
                push(rb(), junk, rb(), 3, cv(0,0,0,1,0,0,0,0,0,0), 0);
                for (int i = 0; i < w; i++) begin
                    if (i == w - 1) push(rb(), junk, 1'b1, 4, cv(0,1,0,1,0,0,0,1,0,0), 1);
                    else            push(rb(), junk, 1'b0, 4, cv(0,0,0,1,0,0,0,1,0,0), 0);
                end
            end
            default: push(rb(), junk, rb(), 3, cv(0,1,0,0,0,0,0,0,0,0), 0);
        endcase
    endtask

    task automatic run_cycle(input cycle_t c);
        run = c.run; opcode = c.opc; mem_ready = c.rdy;
        #1;
        chk("state", 32'(state), 32'(c.st));
        chk("ctl", 32'(ctl_a), 32'(c.ctl));
        chk("retired", retired, cnt);
        chk("state_w4", 32'(state_b), 32'(c.st));
        chk("ctl_w4", 32'(ctl_b), 32'(c.ctl));
        chk("retired_w4", 32'(retired_b), cnt % 16);
        chk("illegal", 32'({illegal, illegal_b}), 32'd0);
        if (c.ret) cnt++;
        @(posedge clk); #1;
    endtask

    task automatic play();
        while (sched.size() > 0) run_cycle(sched.pop_front());
    endtask

    task automatic do_reset();
        arst = 1'b1; run = 1'b0; mem_ready = 1'b0;
        #2;
        chk("rst_state", 32'({state, state_b}), 32'd0);
        chk("rst_ctl", 32'({ctl_a, ctl_b}), 32'd0);
        chk("rst_retired", retired | 32'(retired_b), 32'd0);
        chk("rst_illegal", 32'({illegal, illegal_b}), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        arst = 1'b0;
        cnt = 0;
        sched.delete();
    endtask

    // One instruction from FETCH to next FETCH, with a memory responder that delays ready by w cycles.
    task automatic run_vec(input vec_t v);
        int          cyc, mc, pcw;
        logic [3:0]  seen;
        logic [31:0] r0;
        cyc = 0; mc = 0; pcw = 0; seen = '0; r0 = retired;
        do begin
            run = rb(); opcode = v.opc;
            if (mem_read | mem_write) begin
                mc++;
                mem_ready = (mc >= v.w);
            end else begin
                mem_ready = rb();
            end
            #1;
            seen |= {reg_write, mem_2_reg, branch, jump};
            if (pc_write) pcw++;
            @(posedge clk); #1;
            cyc++;
        end while (state != 3'd1 && cyc < 50);
        chk($sformatf("latency_%b_w%0d", v.opc, v.w), 32'(cyc), 32'(v.len));
        chk($sformatf("retire_%b", v.opc), retired - r0, 32'(v.ret));
        chk($sformatf("memcyc_%b", v.opc), 32'(mc), 32'(v.mem));
        chk($sformatf("seen_%b", v.opc), 32'(seen), 32'(v.seen));
        chk($sformatf("pcw_%b", v.opc), 32'(pcw), 32'd1);
    endtask

    initial begin
        int         k;
        logic [6:0] op;

        tbl.push_back('{OP_R,   0, 4, 1, 0, 4'b1000});
        tbl.push_back('{OP_I,   0, 4, 1, 0, 4'b1000});
        tbl.push_back('{OP_BR,  0, 3, 1, 0, 4'b0010});
        tbl.push_back('{OP_JAL, 0, 3, 1, 0, 4'b0001});
        tbl.push_back('{OP_LD,  4, 8, 1, 4, 4'b1100});
        tbl.push_back('{OP_LD,  1, 5, 1, 1, 4'b1100});
        tbl.push_back('{OP_ST,  1, 4, 1, 1, 4'b0000});
        tbl.push_back('{OP_ST,  3, 6, 1, 3, 4'b0000});
`ifndef ILLEGAL_TRAP_EN
        tbl.push_back('{OP_BAD, 0, 3, 0, 0, 4'b0000});
`endif

        do_reset();

        // IDLE holds without run, then leaves on run.
        for (int i = 0; i < 3; i++) push(1'b0, 7'($urandom), rb(), 0, '0, 0);
        push(1'b1, 7'($urandom), rb(), 0, '0, 0);
        play();

        foreach (tbl[i]) begin
            run_vec(tbl[i]);
            cnt += tbl[i].ret;
        end

        // BR then JAL with a different opcode presented during EXECUTE.
        push_insn(OP_BR, 0, OP_JAL);
        push_insn(OP_JAL, 0, OP_R);
        play();

        for (int n = 0; n < 300; n++) begin
`ifdef ILLEGAL_TRAP_EN
            k = $urandom_range(0, 5);
`else
            k = $urandom_range(0, 6);
`endif
            case (k)
                0: op = OP_R;
                1: op = OP_I;
                2: op = OP_BR;
                3: op = OP_JAL;
                4: op = OP_LD;
                5: op = OP_ST;
                default: op = 7'($urandom);
            endcase
            push_insn(op, $urandom_range(1, 4), 7'($urandom));
        end
        play();

        // 17 retirements wrap the 4-bit counter to 1.
        do_reset();
        push(1'b1, 7'($urandom), rb(), 0, '0, 0);
        for (int i = 0; i < 17; i++) push_insn(OP_R, 0, 7'($urandom));
        play();
        chk("wrap_w4", 32'(retired_b), 32'd1);
        chk("count_17", retired, 32'd17);

        // Reset in the middle of a stalled load.
        push_insn(OP_LD, 5, 7'($urandom));
        for (int i = 0; i < 5; i++) run_cycle(sched.pop_front());
        mem_ready = 1'b0;
        #1;
        chk("mid_mem_read", 32'(mem_read), 32'd1);
        chk("mid_mem_state", 32'(state), 32'd4);
        #2;
        arst = 1'b1;
        #1;
        chk("abort_mem_read", 32'({mem_read, mem_read_b}), 32'd0);
        chk("abort_state", 32'({state, state_b}), 32'd0);
        chk("abort_retired", retired | 32'(retired_b), 32'd0);
        @(posedge clk); #1;
        arst = 1'b0;
        cnt = 0;
        sched.delete();

`ifdef ILLEGAL_TRAP_EN
        push(1'b1, 7'($urandom), rb(), 0, '0, 0);
        push(rb(), 7'($urandom), rb(), 1, cv(1,0,0,0,0,0,0,0,0,0), 0);
        push(rb(), OP_BAD, rb(), 2, '0, 0);
        play();
        for (int i = 0; i < 20; i++) begin
            run = rb(); opcode = 7'($urandom); mem_ready = rb();
            #1;
            chk("trap_state", 32'(state), 32'd6);
            chk("trap_ctl", 32'(ctl_a), 32'd0);
            chk("trap_illegal", 32'(illegal), 32'd1);
            chk("trap_retired", retired, 32'd0);
            @(posedge clk); #1;
        end
`else
        push(1'b1, 7'($urandom), rb(), 0, '0, 0);
        push_insn(OP_BAD, 0, 7'($urandom));
        push_insn(OP_R, 0, 7'($urandom));
        play();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
